image_filter_stream: RTL and testbench
======================================

// Module: image_filter_stream
// PURPOSE
//  Parametrised AXI-Stream 3x3 image filter: buffers raw pixel lines, builds 3x3 windows, applies a
//  runtime-selected kernel (pass/box/sharpen/sobel), and emits results through an internal output FIFO.
//  Owns its own input backpressure and line-done interrupt.
//  Sits between the DMA MM2S and S2MM streams.
// PARAMETERS
//  DATA_W      8    pixel width in bits
//  IMG_W       512  pixels per image line (>=4)
//  FIFO_DEPTH  32   output FIFO entries (power of 2, >=8)
// PORTS
//  axi_clk       in   1       sole clock; all logic on rising edge
//  axi_reset_n   in   1       asynchronous active-low reset
//  i_mode        in   2       0=pass 1=box blur 2=sharpen 3=sobel
//  i_data_valid  in   1       slave tvalid
//  i_data        in   DATA_W  slave tdata, raster order
//  o_data_ready  out  1       slave tready
//  o_data_valid  out  1       master tvalid
//  o_data        out  DATA_W  master tdata
//  i_data_ready  in   1       master tready
//  o_intr        out  1       one-cycle pulse per completed output line
// BEHAVIOUR
//  Reset:
//  - Reset values: o_data_ready=0, o_data_valid=0, o_data=0, o_intr=0.
//  - Pixel count, pointers, FSM and FIFO all clear.
//  - o_data_ready rises the first cycle after reset deasserts.
//  - Reset mid-line discards all buffered and in-flight data.
//  Input side:
//  - 4 line buffers of IMG_W; input writes the buffer after the 3 being read, rotating.
//  - Input handshake = i_data_valid & o_data_ready; it increments pix_cnt.
//  - o_data_ready = (pix_cnt < 4*IMG_W).
//  - When a line read completes, pix_cnt -= IMG_W. If a handshake occurs in the same cycle, the net change is -IMG_W+1.
//  FSM:
//  - IDLE->READ when pix_cnt >= 3*IMG_W; i_mode is sampled on this transition.
//  - A mode change mid-line takes effect on the next line.
//  - READ issues one window per cycle for col 0..IMG_W-1, in order.
//  - READ stalls (no issue) while fifo_cnt + inflight >= FIFO_DEPTH-1, so the FIFO never overflows.
//  - After col IMG_W-1 issues: go to IDLE, the oldest buffer is freed, and o_intr pulses when that window is written to the FIFO.
//  Window and kernel:
//  - Window rows = the 3 oldest buffers (top..bottom). Output line k is centred on input line k+1.
//  - Columns -1 and IMG_W replicate columns 0 and IMG_W-1. There is no vertical padding.
//  - mode0: centre pixel.
//  - mode1: floor(sum9/9); sum is DATA_W+4 bits.
//  - mode2: 5*c - n - s - e - w, signed, clamped to [0, 2^DATA_W-1].
//  - mode3: |Gx| + |Gy| (standard Sobel), saturated to 2^DATA_W-1.
//  Pipeline:
//  - Window issue -> buffer read reg -> arithmetic reg -> clamp/FIFO write: 3 cycles.
//  - The FIFO is first-word-fall-through: o_data_valid rises the cycle after the first write.
//  Output side:
//  - o_data/o_data_valid hold stable while o_data_valid & !i_data_ready.
//  - FIFO pop happens on o_data_valid & i_data_ready.
//  - Simultaneous push and pop keeps fifo_cnt unchanged.
//  - No pixel is ever dropped or duplicated.
// TESTING
//  - IMG_W=8, mode0, ramp 0..39 (5 lines), ready=1 -> 24 outputs = input lines 1..3 in order; 3 o_intr pulses.
//  - mode1, constant 90 image -> every output 90. Single 255 in a zero field -> 28 at the 3x3 neighbours.
//  - mode2, centre 255 with zero neighbours -> 255 (clamped). Centre 0 with neighbours 200 -> 0 (clamped).
//  - mode3, vertical edge (cols 0..3=0, cols 4..7=255) -> outputs at cols 3 and 4 = 255; flat cols = 0.
//  - i_data_ready=0, continuous input -> o_data_ready falls after exactly 4*IMG_W accepts.
//    Releasing ready drains all data, matching the golden model bit-exact.
//  - Assert axi_reset_n=0 mid-line -> next cycle all outputs 0. A new image after release yields a correct stream.

Source files
------------

// File: rtl/image_filter_stream.sv
// Streaming 3x3 image filter: four rotating line buffers feed a windowed kernel
// (pass/box/sharpen/sobel). Results go through a first-word-fall-through output FIFO.
module image_filter_stream #(
  parameter int DATA_W     = 8,
  parameter int IMG_W      = 512,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic [1:0]        i_mode,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  output logic              o_intr
);

  localparam int PW = $clog2(4*IMG_W+1);
  localparam int CW = $clog2(IMG_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = DATA_W + 5;

  localparam logic [PW-1:0] LINE  = PW'(IMG_W);
  localparam logic [PW-1:0] FULL  = PW'(4*IMG_W);
  localparam logic [PW-1:0] START = PW'(3*IMG_W);
  localparam logic [CW-1:0] LAST  = CW'(IMG_W-1);
  localparam logic [AW+1:0] STALL_AT = (AW+2)'(FIFO_DEPTH-1);
  localparam logic signed [RW-1:0] MAXV = $signed({5'b0, {DATA_W{1'b1}}});

  typedef enum logic {IDLE, READ} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     pix_cnt, pix_cnt_nxt;
  logic [1:0]        wr_buf, rd_buf;
  logic [CW-1:0]     wr_col, col;
  logic [1:0]        mode_r;
  logic [DATA_W-1:0] lb [4][IMG_W];

  logic              hs, issue, start_line, free_line, stall;
  logic [AW+1:0]     occ;

  logic [DATA_W-1:0] win_n [9];
  logic [DATA_W-1:0] win   [9];
  logic              s1_v, s1_last;
  logic [1:0]        s1_mode;

  logic signed [RW-1:0] p [9];
  logic [DATA_W+3:0]    sum9, box_u;
  logic signed [RW-1:0] sharp, gx, gy, ax, ay, arith;
  logic signed [RW-1:0] s2_val;
  logic                 s2_v, s2_last;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       fifo_cnt;
  logic              push, pop;
  logic [DATA_W-1:0] fifo_din;

  assign hs        = i_data_valid & o_data_ready;
  assign push      = s2_v;
  assign pop       = o_data_valid & i_data_ready;
  assign free_line = issue && (col == LAST);

  // Everything already issued will land in the FIFO, so count it as occupied
  assign occ   = {1'b0, fifo_cnt} + (AW+2)'(s1_v) + (AW+2)'(s2_v);
  assign stall = (occ >= STALL_AT);

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    start_line = 1'b0;
    case (state)
      IDLE: if (pix_cnt >= START) begin
        state_nxt  = READ;
        start_line = 1'b1;
      end
      READ: begin
        issue = !stall;
        if (issue && col == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pix_cnt_nxt = pix_cnt + PW'(hs) - (free_line ? LINE : '0);

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state        <= IDLE;
      pix_cnt      <= '0;
      o_data_ready <= 1'b0;
      wr_buf       <= '0;
      wr_col       <= '0;
      rd_buf       <= '0;
      col          <= '0;
      mode_r       <= '0;
    end else begin
      state        <= state_nxt;
      pix_cnt      <= pix_cnt_nxt;
      o_data_ready <= (pix_cnt_nxt < FULL);
      if (hs) begin
        if (wr_col == LAST) begin
          wr_col <= '0;
          wr_buf <= wr_buf + 2'd1;
        end else begin
          wr_col <= wr_col + CW'(1);
        end
      end
      if (start_line) begin
        mode_r <= i_mode;
        col    <= '0;
      end
      if (issue) col <= free_line ? '0 : col + CW'(1);
      if (free_line) rd_buf <= rd_buf + 2'd1;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (hs) lb[wr_buf][wr_col] <= i_data;
  end

  // Window gather with horizontal edge replication; rows are the three oldest buffers
  always_comb begin
    logic [CW-1:0] cl, cr;
    logic [1:0]    rr;
    cl = (col == '0)  ? col : col - CW'(1);
    cr = (col == LAST) ? col : col + CW'(1);
    for (int unsigned r = 0; r < 3; r++) begin
      rr             = rd_buf + 2'(r);
      win_n[3*r]     = lb[rr][cl];
      win_n[3*r + 1] = lb[rr][col];
      win_n[3*r + 2] = lb[rr][cr];
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_mode <= '0;
      for (int unsigned i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      s1_v    <= issue;
      s1_last <= free_line;
      if (issue) begin
        s1_mode <= mode_r;
        for (int unsigned i = 0; i < 9; i++) win[i] <= win_n[i];
      end
    end
  end

  always_comb begin
    sum9 = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      p[i] = $signed({5'b0, win[i]});
      sum9 = sum9 + (DATA_W+4)'(win[i]);
    end
    box_u = sum9 / (DATA_W+4)'(9);
    sharp = (p[4] <<< 2) + p[4] - p[1] - p[7] - p[3] - p[5];
    gx    = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
    gy    = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
    ax    = gx[RW-1] ? -gx : gx;
    ay    = gy[RW-1] ? -gy : gy;
    case (s1_mode)
      2'd0:    arith = p[4];
      2'd1:    arith = $signed({1'b0, box_u});
      2'd2:    arith = sharp;
      default: arith = ax + ay;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      s2_v    <= 1'b0;
      s2_last <= 1'b0;
      s2_val  <= '0;
      o_intr  <= 1'b0;
    end else begin
      s2_v    <= s1_v;
      s2_last <= s1_v & s1_last;
      if (s1_v) s2_val <= arith;
      o_intr  <= s2_v & s2_last;
    end
  end

  always_comb begin
    if (s2_val < 0)         fifo_din = '0;
    else if (s2_val > MAXV) fifo_din = '1;
    else                    fifo_din = s2_val[DATA_W-1:0];
  end

  always_ff @(posedge axi_clk) begin
    if (push) mem[wptr] <= fifo_din;
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign o_data_valid = (fifo_cnt != '0);
  assign o_data       = o_data_valid ? mem[rptr] : '0;

endmodule

// File: tb/tb_image_filter_stream.sv
// Scoreboard bench for image_filter_stream (IMG_W=8, small FIFO so backpressure bites).
module tb_image_filter_stream;
  localparam int W = 8;

  logic       axi_clk = 1'b0;
  logic       axi_reset_n = 1'b0;
  logic [1:0] i_mode = '0;
  logic       i_data_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       o_data_ready, o_data_valid, o_intr;
  logic [7:0] o_data;
  logic       i_data_ready = 1'b1;

  int n_chk = 0, n_fail = 0, intr_cnt = 0;
  int exp_q[$];
  int img[$];
  bit hold_prev = 0;
  int hold_data = 0;

  image_filter_stream #(.DATA_W(8), .IMG_W(W), .FIFO_DEPTH(8)) dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n), .i_mode(i_mode),
    .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
    .o_data_valid(o_data_valid), .o_data(o_data), .i_data_ready(i_data_ready),
    .o_intr(o_intr)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic check(string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int px(int r, int c);
    int cc;
    cc = (c < 0) ? 0 : ((c > W-1) ? W-1 : c);
    return img[r*W + cc];
  endfunction

  function automatic int model(int mode, int r, int c);
    int s, gx, gy;
    case (mode)
      0: return px(r, c);
      1: begin
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) s += px(r+dr, c+dc);
        return s / 9;
      end
      2: begin
        s = 5*px(r,c) - px(r-1,c) - px(r+1,c) - px(r,c-1) - px(r,c+1);
        return (s < 0) ? 0 : ((s > 255) ? 255 : s);
      end
      default: begin
        gx = px(r-1,c+1) + 2*px(r,c+1) + px(r+1,c+1) - px(r-1,c-1) - 2*px(r,c-1) - px(r+1,c-1);
        gy = px(r+1,c-1) + 2*px(r+1,c) + px(r+1,c+1) - px(r-1,c-1) - 2*px(r-1,c) - px(r-1,c+1);
        s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (s > 255) ? 255 : s;
      end
    endcase
  endfunction

  // Monitor: compares every transfer against the scoreboard and checks output hold
  always @(negedge axi_clk) begin
    if (axi_reset_n) begin
      if (hold_prev) begin
        check("hold_valid", o_data_valid, 1);
        check("hold_data", o_data, hold_data);
      end
      if (o_data_valid && i_data_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_output: got %0d expected none", o_data);
        end else begin
          check("out_pixel", o_data, exp_q.pop_front());
        end
      end
      hold_prev = o_data_valid && !i_data_ready;
      hold_data = o_data;
      if (o_intr) intr_cnt++;
    end else begin
      hold_prev = 0;
    end
  end

  task automatic send(int v);
    bit acc = 0;
    int guard = 0;
    i_data_valid = 1'b1;
    i_data = 8'(v);
    while (!acc && guard < 300) begin
      @(negedge axi_clk);
      acc = o_data_ready;
      @(posedge axi_clk);
      #1;
      guard++;
    end
    i_data_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
  endtask

  task automatic send_img();
    for (int i = 0; i < img.size(); i++) send(img[i]);
  endtask

  task automatic do_reset(int mode);
    axi_reset_n = 1'b0;
    i_data_valid = 1'b0;
    i_data_ready = 1'b1;
    i_mode = 2'(mode);
    repeat (2) @(posedge axi_clk);
    @(negedge axi_clk);
    check("rst_ready", o_data_ready, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_intr", o_intr, 0);
    exp_q.delete();
    intr_cnt = 0;
    @(posedge axi_clk);
    #1 axi_reset_n = 1'b1;
    @(negedge axi_clk);
    check("ready_before_edge", o_data_ready, 0);
    @(posedge axi_clk);
    #1;
    check("ready_after_release", o_data_ready, 1);
  endtask

  task automatic drain(int lines);
    int g = 0;
    while (exp_q.size() != 0 && g < 1000) begin
      @(posedge axi_clk);
      g++;
    end
    repeat (6) @(posedge axi_clk);
    #1;
    check("drain_left", exp_q.size(), 0);
    check("intr_count", intr_cnt, lines);
  endtask

  initial begin
    int acc, g;

    // Pass-through ramp: outputs are input lines 1..3
    do_reset(0);
    img.delete();
    for (int i = 0; i < 40; i++) img.push_back(i);
    for (int v = 8; v < 32; v++) exp_q.push_back(v);
    send_img();
    drain(3);

    // Box blur of a flat field
    do_reset(1);
    img.delete();
    for (int i = 0; i < 3*W; i++) img.push_back(90);
    for (int c = 0; c < W; c++) exp_q.push_back(90);
    send_img();
    drain(1);

    // Box blur of a single bright pixel at row 1, col 3
    do_reset(1);
    img.delete();
    for (int i = 0; i < 3*W; i++) img.push_back(i == W+3 ? 255 : 0);
    for (int c = 0; c < W; c++) exp_q.push_back((c >= 2 && c <= 4) ? 28 : 0);
    send_img();
    drain(1);

    // Sharpen: isolated 255 clamps high, its neighbours clamp low
    do_reset(2);
    img.delete();
    for (int i = 0; i < 3*W; i++) img.push_back(i == W+3 ? 255 : 0);
    for (int c = 0; c < W; c++) exp_q.push_back(c == 3 ? 255 : 0);
    send_img();
    drain(1);

    // Sharpen: dark hole in a 200 field
    do_reset(2);
    img.delete();
    for (int i = 0; i < 3*W; i++) img.push_back(i == W+3 ? 0 : 200);
    begin
      int sh[8] = '{200, 200, 255, 0, 255, 200, 200, 200};
      for (int c = 0; c < W; c++) exp_q.push_back(sh[c]);
    end
    send_img();
    drain(1);

    // Sobel on a vertical edge between cols 3 and 4
    do_reset(3);
    img.delete();
    for (int i = 0; i < 3*W; i++) img.push_back((i % W) >= 4 ? 255 : 0);
    for (int c = 0; c < W; c++) exp_q.push_back((c == 3 || c == 4) ? 255 : 0);
    send_img();
    drain(1);

    // Output stalled: input must stop after exactly four lines, then drain under random ready
    do_reset(2);
    i_data_ready = 1'b0;
    img.delete();
    for (int i = 0; i < 6*W; i++) img.push_back((i*73 + 29) % 256);
    for (int r = 1; r <= 4; r++)
      for (int c = 0; c < W; c++) exp_q.push_back(model(2, r, c));
    acc = 0;
    g = 0;
    i_data_valid = 1'b1;
    while (g < 200 && acc < 6*W) begin
      i_data = 8'(img[acc]);
      @(negedge axi_clk);
      if (!o_data_ready) break;
      @(posedge axi_clk);
      #1;
      acc++;
      g++;
    end
    i_data_valid = 1'b0;
    check("accepts_at_full", acc, 4*W);
    repeat (4) @(negedge axi_clk);
    check("ready_stays_low", o_data_ready, 0);
    @(posedge axi_clk);
    #1;
    fork
      begin
        for (int i = acc; i < 6*W; i++) send(img[i]);
      end
      begin
        repeat (150) begin
          @(posedge axi_clk);
          #1 i_data_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_data_ready = 1'b1;
    drain(4);

    // Reset in the middle of a line discards everything buffered
    do_reset(0);
    for (int i = 0; i < 12; i++) send(100 + i);
    @(posedge axi_clk);
    #1 axi_reset_n = 1'b0;
    #1;
    check("midrst_ready", o_data_ready, 0);
    check("midrst_valid", o_data_valid, 0);
    check("midrst_data", o_data, 0);
    check("midrst_intr", o_intr, 0);
    do_reset(0);
    img.delete();
    for (int i = 0; i < 3*W; i++) img.push_back(i);
    for (int v = W; v < 2*W; v++) exp_q.push_back(v);
    send_img();
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
